esm_issue_buffer: RTL and testbench

- Instruction window that sits directly around the ESM dependency analyser (IRT/IDT core).
- Upstream role: accepts decoded instructions, allocates a buffer slot, and drives buffer_index and Instr_in to the analyser. Also owns valid_entries.
- Downstream role: consumes the analyser's independent_instr mask, selects one ready entry per cycle, and issues it through a valid/ready handshake.
- Freeing a slot on issue drops its valid_entries bit, which releases its dependents in the analyser.

---
 rtl/esm_pkg.sv | 22 ++
 rtl/esm_issue_buffer_if.sv | 34 +++
 rtl/esm_rr_picker.sv | 30 +++
 rtl/esm_issue_buffer.sv | 146 ++++++++++++++
 tb/tb_esm_issue_buffer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/esm_pkg.sv
// Shared types, widths and reset constants for the ESM issue buffer.
// Optional build macro used by the consumers of this package: ESM_AGE_PRIORITY_EN.
package esm_pkg;

  localparam int unsigned INSTR_W = 32;

  // Index width for a buffer of n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic               valid;
    logic               inflight;
    logic               fresh;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  localparam logic               ISSUE_VALID_RST = 1'b0;
  localparam logic [INSTR_W-1:0] ISSUE_INSTR_RST = '0;

endpackage

// File: rtl/esm_issue_buffer_if.sv
// Allocation, analyser and issue signals of the ESM issue buffer.
// master = the buffer, slave = upstream/analyser/downstream environment.
interface esm_issue_buffer_if #(
  parameter int unsigned Instruction_word_size = esm_pkg::INSTR_W,
  parameter int unsigned bs                    = 16
);
  localparam int unsigned IW = esm_pkg::idx_w(bs);

  logic                             in_valid;
  logic                             in_ready;
  logic [Instruction_word_size-1:0] in_instr;
  logic                             alloc_fire;
  logic [IW-1:0]                    buffer_index;
  logic [Instruction_word_size-1:0] Instr_out;
  logic [0:bs-1]                    valid_entries;
  logic [0:bs-1]                    independent_instr;
  logic                             issue_valid;
  logic                             issue_ready;
  logic [Instruction_word_size-1:0] issue_instr;
  logic [IW-1:0]                    issue_index;

  modport master (
    input  in_valid, in_instr, independent_instr, issue_ready,
    output in_ready, alloc_fire, buffer_index, Instr_out, valid_entries,
           issue_valid, issue_instr, issue_index
  );

  modport slave (
    output in_valid, in_instr, independent_instr, issue_ready,
    input  in_ready, alloc_fire, buffer_index, Instr_out, valid_entries,
           issue_valid, issue_instr, issue_index
  );

endinterface

// File: rtl/esm_rr_picker.sv
// Combinational round-robin picker: first set bit of eligible at or above
// start, wrapping modulo bs (bs is a power of two, so wrap is truncation).
module esm_rr_picker #(
  parameter  int unsigned bs = 16,
  localparam int unsigned IW = esm_pkg::idx_w(bs)
) (
  input  logic [0:bs-1] eligible,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [IW-1:0] cand;

  // NOTE: every variable written here gets a default before the loop;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = 0; k < bs; k++) begin
      cand = start + IW'(k);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/esm_issue_buffer.sv
// Instruction window around the ESM dependency analyser: allocates slots,
// tracks occupancy and issues one ready entry per cycle through valid/ready.
// ESM_AGE_PRIORITY_EN selects oldest-first picking; round-robin otherwise.
module esm_issue_buffer #(
  parameter int unsigned Instruction_word_size = esm_pkg::INSTR_W,  // must equal INSTR_W
  parameter int unsigned bs                    = 16
) (
  input logic                clk,
  input logic                rst,
  esm_issue_buffer_if.master bus
);
  import esm_pkg::*;

  localparam int unsigned IW = idx_w(bs);

  entry_t                           ent [bs];
  logic [0:bs-1]                    eligible;
  logic [0:bs-1]                    valid_mask;
  logic                             full;
  logic                             in_ready;
  logic                             alloc_fire;
  logic                             issue_fire;
  logic                             load;
  logic                             pick_found;
  logic [IW-1:0]                    buffer_index;
  logic [IW-1:0]                    pick_idx;
  logic                             issue_valid;
  logic [Instruction_word_size-1:0] issue_instr;
  logic [IW-1:0]                    issue_index;

  // Lowest free slot, derived from registered valid bits only, so a slot
  // freed this cycle becomes allocatable on the next one.
  always_comb begin
    full         = 1'b1;
    buffer_index = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (!ent[i].valid) begin
        full         = 1'b0;
        buffer_index = IW'(i);
      end
    end
  end

  always_comb begin
    eligible   = '0;
    valid_mask = '0;
    for (int i = 0; i < bs; i++) begin
      valid_mask[i] = ent[i].valid;
      eligible[i]   = ent[i].valid & ~ent[i].inflight & ~ent[i].fresh &
                      bus.independent_instr[i];
    end
  end

  assign in_ready   = !full;
  assign alloc_fire = bus.in_valid && in_ready;
  assign issue_fire = issue_valid && bus.issue_ready;
  assign load       = (!issue_valid || bus.issue_ready) && pick_found;

`ifdef ESM_AGE_PRIORITY_EN
  logic [0:bs-1] age [bs];  // age[i][j]: entry i is older than entry j
  logic          older_elig;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    older_elig = 1'b0;
    for (int i = bs - 1; i >= 0; i--) begin
      older_elig = 1'b0;
      for (int j = 0; j < bs; j++) older_elig = older_elig | (eligible[j] & age[j][i]);
      if (eligible[i] && !older_elig) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] rr_ptr;

  esm_rr_picker #(.bs(bs)) u_picker (
    .eligible (eligible),
    .start    (rr_ptr),
    .found    (pick_found),
    .index    (pick_idx)
  );
`endif

  // NOTE: the instruction payload shares the async reset with the flags so the
  // whole window is discarded in one step; the storage is only bs words deep.
  // NOTE: state is updated with non-blocking assignments only, so every read
  // below sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < bs; i++) ent[i] <= '0;
      issue_valid <= ISSUE_VALID_RST;
      issue_instr <= ISSUE_INSTR_RST;
      issue_index <= '0;
`ifdef ESM_AGE_PRIORITY_EN
      for (int i = 0; i < bs; i++) age[i] <= '0;
`else
      rr_ptr      <= '0;
`endif
    end else begin
      for (int i = 0; i < bs; i++) ent[i].fresh <= 1'b0;

      if (issue_fire) begin
        ent[issue_index].valid    <= 1'b0;
        ent[issue_index].inflight <= 1'b0;
      end

      if (alloc_fire) begin
        ent[buffer_index].valid <= 1'b1;
        ent[buffer_index].fresh <= 1'b1;
        ent[buffer_index].instr <= bus.in_instr;
`ifdef ESM_AGE_PRIORITY_EN
        age[buffer_index] <= '0;
        for (int i = 0; i < bs; i++) begin
          if (ent[i].valid) age[i][buffer_index] <= 1'b1;
        end
`endif
      end

      // The picked entry is never issue_index: that one is still inflight.
      if (load) begin
        issue_valid             <= 1'b1;
        issue_instr             <= ent[pick_idx].instr;
        issue_index             <= pick_idx;
        ent[pick_idx].inflight  <= 1'b1;
`ifndef ESM_AGE_PRIORITY_EN
        rr_ptr                  <= pick_idx + IW'(1);
`endif
      end else if (issue_fire) begin
        issue_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.alloc_fire    = alloc_fire;
  assign bus.buffer_index  = buffer_index;
  assign bus.Instr_out     = bus.in_instr;
  assign bus.valid_entries = valid_mask;
  assign bus.issue_valid   = issue_valid;
  assign bus.issue_instr   = issue_instr;
  assign bus.issue_index   = issue_index;

endmodule

// File: tb/tb_esm_issue_buffer.sv
// Directed bench for esm_issue_buffer with bs=4; the age-order scenario runs
// only when ESM_AGE_PRIORITY_EN is defined.
module tb_esm_issue_buffer;

  localparam int unsigned W  = 32;
  localparam int unsigned BS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  esm_issue_buffer_if #(.Instruction_word_size(W), .bs(BS)) bus ();

  esm_issue_buffer #(.Instruction_word_size(W), .bs(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    bus.in_valid          = 1'b0;
    bus.in_instr          = '0;
    bus.independent_instr = '0;
    bus.issue_ready       = 1'b0;
    #1;
    total++; if (bus.valid_entries !== 4'b0000) begin bad++; $display("FAIL rst_valid got=%b exp=0000", bus.valid_entries); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL rst_issue_valid got=%b exp=0", bus.issue_valid); end
    total++; if (bus.issue_instr !== 32'h0) begin bad++; $display("FAIL rst_issue_instr got=%h exp=0", bus.issue_instr); end
    total++; if (bus.buffer_index !== 2'd0) begin bad++; $display("FAIL rst_buffer_index got=%0d exp=0", bus.buffer_index); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Fill A..D with issue_ready low; first issue appears 2 cycles after A.
  task automatic test_fill();
    bus.independent_instr = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = 32'hA000_0000 + k;
      #1;
      total++; if (bus.buffer_index !== 2'(k)) begin bad++; $display("FAIL fill_index got=%0d exp=%0d", bus.buffer_index, k); end
      total++; if (bus.alloc_fire !== 1'b1) begin bad++; $display("FAIL fill_alloc got=%b exp=1", bus.alloc_fire); end
      total++; if (bus.Instr_out !== 32'hA000_0000 + k) begin bad++; $display("FAIL fill_passthru got=%h exp=%h", bus.Instr_out, 32'hA000_0000 + k); end
      total++; if (bus.issue_valid !== (k == 3)) begin bad++; $display("FAIL fill_issue_valid k=%0d got=%b exp=%b", k, bus.issue_valid, k == 3); end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.valid_entries !== 4'b1111) begin bad++; $display("FAIL full_valid got=%b exp=1111", bus.valid_entries); end
    total++; if (bus.issue_index !== 2'd0) begin bad++; $display("FAIL first_index got=%0d exp=0", bus.issue_index); end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 2'd0 || bus.issue_instr !== 32'hA000_0000) begin
        bad++; $display("FAIL hold c=%0d got v=%b idx=%0d instr=%h exp v=1 idx=0 instr=a0000000", c, bus.issue_valid, bus.issue_index, bus.issue_instr);
      end
      total++; if (bus.valid_entries !== 4'b1111) begin bad++; $display("FAIL hold_valid got=%b exp=1111", bus.valid_entries); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_v;
    bus.issue_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      exp_v = 4'b1111 >> k;
      total++; if (bus.issue_index !== 2'(k) || bus.issue_instr !== 32'hA000_0000 + k) begin
        bad++; $display("FAIL b2b_order got idx=%0d instr=%h exp idx=%0d", bus.issue_index, bus.issue_instr, k);
      end
      total++; if (bus.valid_entries !== exp_v) begin bad++; $display("FAIL b2b_valid got=%b exp=%b", bus.valid_entries, exp_v); end
    end
    @(negedge clk);
    total++; if (bus.issue_valid !== 1'b0 || bus.valid_entries !== 4'b0000) begin
      bad++; $display("FAIL drained got v=%b valid=%b exp v=0 valid=0000", bus.issue_valid, bus.valid_entries);
    end
    bus.issue_ready = 1'b0;
  endtask

  task automatic test_mask();
    bus.independent_instr = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = 32'hB000_0000 + k;
      @(negedge clk);
    end
    bus.in_valid          = 1'b0;
    bus.independent_instr = 4'b0100;
    @(negedge clk);
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 2'd1 || bus.issue_instr !== 32'hB000_0001) begin
      bad++; $display("FAIL mask_pick got v=%b idx=%0d instr=%h exp v=1 idx=1 instr=b0000001", bus.issue_valid, bus.issue_index, bus.issue_instr);
    end
    bus.issue_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.valid_entries !== 4'b1011) begin bad++; $display("FAIL mask_free got=%b exp=1011", bus.valid_entries); end
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL mask_idle got=%b exp=0", bus.issue_valid); end
    bus.issue_ready       = 1'b0;
    bus.independent_instr = 4'b0000;
  endtask

  task automatic test_full_free();
    bus.in_valid = 1'b1;
    bus.in_instr = 32'hE000_0000;
    #1;
    total++; if (bus.buffer_index !== 2'd1) begin bad++; $display("FAIL refill_index got=%0d exp=1", bus.buffer_index); end
    @(negedge clk);
    bus.in_valid          = 1'b0;
    bus.independent_instr = 4'b0010;
    @(negedge clk);
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 2'd2 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL ff_setup got v=%b idx=%0d rdy=%b exp v=1 idx=2 rdy=0", bus.issue_valid, bus.issue_index, bus.in_ready);
    end
    bus.issue_ready       = 1'b1;
    bus.in_valid          = 1'b1;
    bus.in_instr          = 32'hF000_0000;
    bus.independent_instr = 4'b0000;
    #1;
    total++; if (bus.alloc_fire !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL ff_same_cycle got fire=%b rdy=%b exp fire=0 rdy=0", bus.alloc_fire, bus.in_ready);
    end
    @(negedge clk);
    total++; if (bus.buffer_index !== 2'd2 || bus.alloc_fire !== 1'b1) begin
      bad++; $display("FAIL ff_next got idx=%0d fire=%b exp idx=2 fire=1", bus.buffer_index, bus.alloc_fire);
    end
    total++; if (bus.valid_entries !== 4'b1101 || bus.issue_valid !== 1'b0) begin
      bad++; $display("FAIL ff_state got valid=%b v=%b exp valid=1101 v=0", bus.valid_entries, bus.issue_valid);
    end
    bus.issue_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.valid_entries !== 4'b1111) begin bad++; $display("FAIL ff_refilled got=%b exp=1111", bus.valid_entries); end
  endtask

  task automatic test_reset_mid();
    bus.independent_instr = 4'b1000;
    @(negedge clk);
    total++; if (bus.issue_index !== 2'd0 || bus.issue_valid !== 1'b1) begin
      bad++; $display("FAIL rm_wrap got idx=%0d v=%b exp idx=0 v=1", bus.issue_index, bus.issue_valid);
    end
    bus.issue_ready       = 1'b1;
    bus.independent_instr = 4'b0000;
    @(negedge clk);
    bus.issue_ready       = 1'b0;
    bus.independent_instr = 4'b0001;
    @(negedge clk);
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 2'd3 || bus.valid_entries !== 4'b0111) begin
      bad++; $display("FAIL rm_setup got v=%b idx=%0d valid=%b exp v=1 idx=3 valid=0111", bus.issue_valid, bus.issue_index, bus.valid_entries);
    end
    bus.independent_instr = 4'b0000;
    #2 rst = 1'b1;
    #1;
    total++; if (bus.issue_valid !== 1'b0 || bus.valid_entries !== 4'b0000 || bus.issue_index !== 2'd0) begin
      bad++; $display("FAIL rm_async got v=%b valid=%b idx=%0d exp v=0 valid=0000 idx=0", bus.issue_valid, bus.valid_entries, bus.issue_index);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1 || bus.buffer_index !== 2'd0) begin
      bad++; $display("FAIL rm_release got rdy=%b idx=%0d exp rdy=1 idx=0", bus.in_ready, bus.buffer_index);
    end
  endtask

`ifdef ESM_AGE_PRIORITY_EN
  // Slot 2 is allocated before slots 0 and 3; slot 1 is kept non-ready.
  task automatic test_age();
    logic [1:0]  exp_idx [3];
    logic [31:0] exp_ins [3];
    exp_idx[0] = 2'd2; exp_ins[0] = 32'hC000_0002;
    exp_idx[1] = 2'd0; exp_ins[1] = 32'hD000_0000;
    exp_idx[2] = 2'd3; exp_ins[2] = 32'hD000_0003;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_instr = 32'hC000_0000 + k;
      @(negedge clk);
    end
    bus.in_valid          = 1'b0;
    bus.independent_instr = 4'b1000;
    @(negedge clk);
    bus.issue_ready       = 1'b1;
    bus.independent_instr = 4'b0000;
    @(negedge clk);
    bus.issue_ready = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_instr    = 32'hD000_0000;
    #1;
    total++; if (bus.buffer_index !== 2'd0) begin bad++; $display("FAIL age_alloc0 got=%0d exp=0", bus.buffer_index); end
    @(negedge clk);
    bus.in_instr = 32'hD000_0003;
    #1;
    total++; if (bus.buffer_index !== 2'd3) begin bad++; $display("FAIL age_alloc3 got=%0d exp=3", bus.buffer_index); end
    @(negedge clk);
    bus.in_valid          = 1'b0;
    bus.independent_instr = 4'b1011;
    bus.issue_ready       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== exp_idx[k] || bus.issue_instr !== exp_ins[k]) begin
        bad++; $display("FAIL age_order k=%0d got v=%b idx=%0d instr=%h exp idx=%0d instr=%h", k, bus.issue_valid, bus.issue_index, bus.issue_instr, exp_idx[k], exp_ins[k]);
      end
    end
    @(negedge clk);
    total++; if (bus.issue_valid !== 1'b0 || bus.valid_entries !== 4'b0100) begin
      bad++; $display("FAIL age_end got v=%b valid=%b exp v=0 valid=0100", bus.issue_valid, bus.valid_entries);
    end
    bus.issue_ready       = 1'b0;
    bus.independent_instr = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_back_to_back();
    test_mask();
    test_full_free();
    test_reset_mid();
`ifdef ESM_AGE_PRIORITY_EN
    test_age();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
